// File: rtl/block_move_ctrl.sv
// Registered move controller for the falling tetromino.
// Turns synchronised button levels into single moves, with press-edge detection and
// auto-repeat, and keeps each move inside the board. Every move is confirmed by the
// collision checker through a req/done handshake. The committed position changes only
// when the checker approves the move.
module block_move_ctrl #(
    parameter int unsigned POS_W      = 10,
    parameter int unsigned ROT_W      = 2,
    parameter int unsigned X_MAX      = 9,
    parameter int unsigned Y_MAX      = 19,
    parameter int unsigned SPAWN_X    = 4,
    parameter int unsigned DAS_DELAY  = 16,
    parameter int unsigned ARR_PERIOD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             left,
    input  logic             right,
    input  logic             down,
    input  logic             ro,
    input  logic             spawn,
    output logic             chk_req,
    output logic [POS_W-1:0] chk_x,
    output logic [POS_W-1:0] chk_y,
    output logic [ROT_W-1:0] chk_rot,
    input  logic             chk_done,
    input  logic             chk_ok,
    output logic [POS_W-1:0] block_pos_x,
    output logic [POS_W-1:0] block_pos_y,
    output logic [ROT_W-1:0] rotate,
    output logic             moved,
    output logic             blocked
);

    localparam int unsigned CNT_W = $clog2(DAS_DELAY + ARR_PERIOD + 1);
    localparam logic [CNT_W-1:0] DasCnt  = CNT_W'(DAS_DELAY);
    // Reaching DAS+ARR wraps back to DAS, so the repeat fires every ARR cycles.
    localparam logic [CNT_W-1:0] WrapCnt = CNT_W'(DAS_DELAY + ARR_PERIOD);

    typedef enum logic [0:0] {StIdle, StCheck} state_e;

    state_e state_q, state_d;

    // Previous button levels, bit order {ro, down, right, left}.
    logic [3:0]            prev_q;
    // Held counters for the repeating buttons, index 0 left, 1 right, 2 down.
    logic [2:0][CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [2:0]            hold_btn, rep_ev;

    logic ev_left, ev_right, ev_down, ev_rot;
    logic p_left_q, p_right_q, p_down_q, p_rot_q;
    logic p_left_d, p_right_d, p_down_d, p_rot_d;

    logic [POS_W-1:0] pos_x_q, pos_y_q, chk_x_q, chk_y_q;
    logic [ROT_W-1:0] rot_q, chk_rot_q;
    logic             moved_q, blocked_q;

    logic             take_left, take_right, take_down, take_rot;
    logic             load_chk, drop, commit, reject, do_spawn;
    logic [POS_W-1:0] cand_x, cand_y;
    logic [ROT_W-1:0] cand_rot;

    assign hold_btn = {down, right, left};

    for (genvar i = 0; i < 3; i++) begin : g_rep
        assign cnt_inc[i] = cnt_q[i] + CNT_W'(1);
        assign cnt_d[i]   = !hold_btn[i]           ? '0     :
                            (cnt_inc[i] == WrapCnt) ? DasCnt : cnt_inc[i];
        assign rep_ev[i]  = hold_btn[i] && (cnt_d[i] == DasCnt);
    end

    assign ev_left  = (left  & ~prev_q[0]) | rep_ev[0];
    assign ev_right = (right & ~prev_q[1]) | rep_ev[1];
    assign ev_down  = (down  & ~prev_q[2]) | rep_ev[2];
    assign ev_rot   =  ro    & ~prev_q[3];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: spawn, move selection with board clamping, and checker response.
    always_comb begin
        state_d    = state_q;
        take_left  = 1'b0;
        take_right = 1'b0;
        take_down  = 1'b0;
        take_rot   = 1'b0;
        load_chk   = 1'b0;
        drop       = 1'b0;
        commit     = 1'b0;
        reject     = 1'b0;
        do_spawn   = 1'b0;
        cand_x     = pos_x_q;
        cand_y     = pos_y_q;
        cand_rot   = rot_q;
        if (spawn) begin
            // Spawn abandons any outstanding check.
            do_spawn = 1'b1;
            state_d  = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (p_rot_q) begin
                        take_rot = 1'b1;
                        cand_rot = rot_q + ROT_W'(1);
                        load_chk = 1'b1;
                    end else if (p_left_q) begin
                        take_left = 1'b1;
                        if (pos_x_q == '0) begin
                            drop = 1'b1;
                        end else begin
                            cand_x   = pos_x_q - POS_W'(1);
                            load_chk = 1'b1;
                        end
                    end else if (p_right_q) begin
                        take_right = 1'b1;
                        if (pos_x_q == POS_W'(X_MAX)) begin
                            drop = 1'b1;
                        end else begin
                            cand_x   = pos_x_q + POS_W'(1);
                            load_chk = 1'b1;
                        end
                    end else if (p_down_q) begin
                        take_down = 1'b1;
                        if (pos_y_q == POS_W'(Y_MAX)) begin
                            drop = 1'b1;
                        end else begin
                            cand_y   = pos_y_q + POS_W'(1);
                            load_chk = 1'b1;
                        end
                    end
                    if (load_chk) begin
                        state_d = StCheck;
                    end
                end
                StCheck: begin
                    if (chk_done) begin
                        state_d = StIdle;
                        commit  = chk_ok;
                        reject  = ~chk_ok;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Sticky pending bits: new events set, selection clears, spawn and left+right clear.
    always_comb begin
        p_left_d  = (p_left_q  & ~take_left)  | ev_left;
        p_right_d = (p_right_q & ~take_right) | ev_right;
        p_down_d  = (p_down_q  & ~take_down)  | ev_down;
        p_rot_d   = (p_rot_q   & ~take_rot)   | ev_rot;
        if (left && right) begin
            p_left_d  = 1'b0;
            p_right_d = 1'b0;
        end
        if (do_spawn) begin
            p_left_d  = 1'b0;
            p_right_d = 1'b0;
            p_down_d  = 1'b0;
            p_rot_d   = 1'b0;
        end
    end

    // Datapath registers: button history, pending moves, candidate and committed position.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q    <= '0;
            cnt_q     <= '0;
            p_left_q  <= 1'b0;
            p_right_q <= 1'b0;
            p_down_q  <= 1'b0;
            p_rot_q   <= 1'b0;
            chk_x_q   <= POS_W'(SPAWN_X);
            chk_y_q   <= '0;
            chk_rot_q <= '0;
            pos_x_q   <= POS_W'(SPAWN_X);
            pos_y_q   <= '0;
            rot_q     <= '0;
            moved_q   <= 1'b0;
            blocked_q <= 1'b0;
        end else begin
            prev_q    <= {ro, down, right, left};
            cnt_q     <= cnt_d;
            p_left_q  <= p_left_d;
            p_right_q <= p_right_d;
            p_down_q  <= p_down_d;
            p_rot_q   <= p_rot_d;
            if (load_chk) begin
                chk_x_q   <= cand_x;
                chk_y_q   <= cand_y;
                chk_rot_q <= cand_rot;
            end
            if (do_spawn) begin
                pos_x_q <= POS_W'(SPAWN_X);
                pos_y_q <= '0;
                rot_q   <= '0;
            end else if (commit) begin
                pos_x_q <= chk_x_q;
                pos_y_q <= chk_y_q;
                rot_q   <= chk_rot_q;
            end
            moved_q   <= commit;
            blocked_q <= reject | drop;
        end
    end

    // Outputs: request follows the CHECK state, everything else is registered.
    always_comb begin
        chk_req     = (state_q == StCheck);
        chk_x       = chk_x_q;
        chk_y       = chk_y_q;
        chk_rot     = chk_rot_q;
        block_pos_x = pos_x_q;
        block_pos_y = pos_y_q;
        rotate      = rot_q;
        moved       = moved_q;
        blocked     = blocked_q;
    end

endmodule
